// File: rtl/clkgate_ctrl_pkg.sv
// Shared types and constants for the clock-gate enable controller.
// Also provides the elaboration-time range check used on cycle-count parameters.
package clkgate_ctrl_pkg;
    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_COUNT = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    localparam int CG_CNT_W = 8;
endpackage

`ifndef CG_PARAM_RANGE_CHECK
`define CG_PARAM_RANGE_CHECK(P) \
    if ((P) < 1 || (P) > 255) begin \
        $error("clkgate_enable_ctrl: parameter out of range 1..255"); \
    end
`endif

// File: rtl/clkgate_sat_cnt.sv
// Clear/increment counter that holds at all-ones; clear has priority over increment.
// Single-cycle update, no flow control.
module clkgate_sat_cnt #(
    parameter int W = 8
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/clkgate_enable_ctrl.sv
// Drives E of the clock-gate cell: gates after IDLE_CYCLES idle edges, wakes on demand, ready after WAKE_CYCLES.
// Optional gated-cycle statistics counter under CLKGATE_STATS_EN.
module clkgate_enable_ctrl
    import clkgate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
`ifdef CLKGATE_STATS_EN
    ,parameter int STAT_W     = 16
`endif
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              req,
    input  logic              busy,
    input  logic              sw_en,
    output logic              E,
    output logic              ready,
    output logic              gated
`ifdef CLKGATE_STATS_EN
    ,output logic [STAT_W-1:0] gated_cycles
`endif
);
    `CG_PARAM_RANGE_CHECK(IDLE_CYCLES)
    `CG_PARAM_RANGE_CHECK(WAKE_CYCLES)

    localparam logic [CG_CNT_W-1:0] IDLE_LAST = CG_CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CG_CNT_W-1:0] WAKE_LAST = CG_CNT_W'(WAKE_CYCLES - 1);

    cg_state_e           state_q, state_d;
    logic                e_q, e_d;
    logic                ready_q, ready_d;
    logic                gated_q, gated_d;
    logic [CG_CNT_W-1:0] idle_cnt_q;
    logic [CG_CNT_W-1:0] wake_cnt_q;
    logic                idle, counting, gate_now, wake_done;
    logic                idle_inc, wake_inc;

    assign idle      = !req && !busy && sw_en;
    assign counting  = (state_q == CG_RUN) || (state_q == CG_COUNT);
    // idle_cnt is always zero in RUN, so IDLE_CYCLES==1 gates straight from RUN
    assign gate_now  = counting && idle && (idle_cnt_q == IDLE_LAST);
    assign wake_done = (state_q == CG_WAKE) && (wake_cnt_q == WAKE_LAST);
    assign idle_inc  = counting && idle && !gate_now;
    assign wake_inc  = (state_q == CG_WAKE) && !wake_done;

    clkgate_sat_cnt #(.W(CG_CNT_W)) u_idle_cnt (
        .CK    (CK),
        .RN    (RN),
        .clr_i (!idle_inc),
        .inc_i (idle_inc),
        .cnt_o (idle_cnt_q)
    );

    clkgate_sat_cnt #(.W(CG_CNT_W)) u_wake_cnt (
        .CK    (CK),
        .RN    (RN),
        .clr_i (!wake_inc),
        .inc_i (wake_inc),
        .cnt_o (wake_cnt_q)
    );

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        ready_d = ready_q;
        gated_d = gated_q;
        case (state_q)
            CG_RUN, CG_COUNT: begin
                if (gate_now) begin
                    state_d = CG_GATED;
                    e_d     = 1'b0;
                    ready_d = 1'b0;
                    gated_d = 1'b1;
                end else if (idle) begin
                    state_d = CG_COUNT;
                end else begin
                    state_d = CG_RUN;
                end
            end
            CG_GATED: begin
                if (!idle) begin
                    state_d = CG_WAKE;
                    e_d     = 1'b1;
                    gated_d = 1'b0;
                end
            end
            CG_WAKE: begin
                // wake always runs to completion regardless of inputs
                if (wake_done) begin
                    state_d = CG_RUN;
                    ready_d = 1'b1;
                end
            end
            default: state_d = CG_RUN;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= CG_RUN;
            e_q     <= 1'b1;
            ready_q <= 1'b1;
            gated_q <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            gated_q <= gated_d;
        end
    end

    assign E     = e_q;
    assign ready = ready_q;
    assign gated = gated_q;

`ifdef CLKGATE_STATS_EN
    clkgate_sat_cnt #(.W(STAT_W)) u_stat_cnt (
        .CK    (CK),
        .RN    (RN),
        .clr_i (1'b0),
        .inc_i (!e_q),
        .cnt_o (gated_cycles)
    );
`endif
endmodule

// File: tb/tb_clkgate_enable_ctrl.sv
// Directed plus random stimulus against a run-length reference model of the gating controller.
module tb_clkgate_enable_ctrl;
    localparam int IDLE_N = 4;
    localparam int WAKE_N = 2;
`ifdef CLKGATE_STATS_EN
    localparam int STAT_W   = 4;
    localparam int STAT_MAX = (1 << STAT_W) - 1;
`endif

    logic CK = 1'b0;
    logic RN = 1'b0;
    logic req = 1'b0;
    logic busy = 1'b0;
    logic sw_en = 1'b1;
    logic E, ready, gated;
`ifdef CLKGATE_STATS_EN
    logic [STAT_W-1:0] gated_cycles;
`endif

    int total = 0;
    int bad = 0;

    // reference model: gated flag, remaining wake edges, current idle run length
    int m_gated = 0;
    int m_wake_left = 0;
    int m_run = 0;
    int m_stat = 0;

    always #5 CK = ~CK;

    clkgate_enable_ctrl #(
        .IDLE_CYCLES (IDLE_N),
        .WAKE_CYCLES (WAKE_N)
`ifdef CLKGATE_STATS_EN
        ,.STAT_W     (STAT_W)
`endif
    ) dut (
        .CK    (CK),
        .RN    (RN),
        .req   (req),
        .busy  (busy),
        .sw_en (sw_en),
        .E     (E),
        .ready (ready),
        .gated (gated)
`ifdef CLKGATE_STATS_EN
        ,.gated_cycles (gated_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gated = 0;
        m_wake_left = 0;
        m_run = 0;
        m_stat = 0;
    endtask

    task automatic model_edge(input bit idle_s);
`ifdef CLKGATE_STATS_EN
        if (m_gated != 0 && m_stat < STAT_MAX) m_stat++;
`endif
        if (m_gated != 0) begin
            if (!idle_s) begin
                m_gated = 0;
                m_wake_left = WAKE_N;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (idle_s) begin
            m_run++;
            if (m_run == IDLE_N) begin
                m_gated = 1;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_E"},     32'(E),     32'(m_gated == 0));
        chk({tag, "_ready"}, 32'(ready), 32'(m_gated == 0 && m_wake_left == 0));
        chk({tag, "_gated"}, 32'(gated), 32'(m_gated != 0));
`ifdef CLKGATE_STATS_EN
        chk({tag, "_stat"},  32'(gated_cycles), 32'(m_stat));
`endif
    endtask

    // called at a falling edge: drive, let one rising edge pass, check at the next falling edge
    task automatic cyc(input string tag, input logic r, input logic b, input logic s);
        req = r;
        busy = b;
        sw_en = s;
        @(posedge CK);
        model_edge(!r && !b && s);
        @(negedge CK);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 RN = 1'b0;
        #1;
        chk({tag, "_rst_E"},     32'(E),     32'd1);
        chk({tag, "_rst_ready"}, 32'(ready), 32'd1);
        chk({tag, "_rst_gated"}, 32'(gated), 32'd0);
`ifdef CLKGATE_STATS_EN
        chk({tag, "_rst_stat"},  32'(gated_cycles), 32'd0);
`endif
        model_reset();
        @(negedge CK);
        RN = 1'b1;
    endtask

    initial begin
        @(negedge CK);
        do_reset("init");

        // 1: plain idle gates on the 4th edge
        for (int i = 0; i < 3; i++) cyc("t1_idle", 0, 0, 1);
        chk("t1_E_before", 32'(E), 32'd1);
        cyc("t1_gate", 0, 0, 1);
        chk("t1_E_gated", 32'(E), 32'd0);
        chk("t1_ready_gated", 32'(ready), 32'd0);

        // 3: wake from gated, drop req mid-wake
        cyc("t3_req", 1, 0, 1);
        chk("t3_E_up", 32'(E), 32'd1);
        chk("t3_ready_lo", 32'(ready), 32'd0);
        cyc("t3_drop", 0, 0, 1);
        cyc("t3_done", 0, 0, 1);
        chk("t3_ready_up", 32'(ready), 32'd1);

        // 2: req pulse on 3rd idle edge restarts the run
        cyc("t2_req", 1, 0, 1);
        cyc("t2_i1", 0, 0, 1);
        cyc("t2_i2", 0, 0, 1);
        cyc("t2_pulse", 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc("t2_idle", 0, 0, 1);
        chk("t2_E_still_on", 32'(E), 32'd1);
        cyc("t2_gate", 0, 0, 1);
        chk("t2_E_gated", 32'(E), 32'd0);

        // 4: req on the final idle edge wins
        cyc("t4_wake", 0, 1, 1);
        for (int i = 0; i < WAKE_N; i++) cyc("t4_wk", 0, 0, 1);
        for (int i = 0; i < 2; i++) cyc("t4_idle", 0, 0, 1);
        cyc("t4_i3", 0, 0, 1);
        cyc("t4_last", 1, 0, 1);
        chk("t4_E_on", 32'(E), 32'd1);
        for (int i = 0; i < 100; i++) cyc("t4_swoff", 0, 0, 0);
        chk("t4_swoff_E", 32'(E), 32'd1);

        // 5: sw_en drop wakes, then async reset while gated
        for (int i = 0; i < IDLE_N; i++) cyc("t5_idle", 0, 0, 1);
        chk("t5_gated", 32'(gated), 32'd1);
        cyc("t5_sw0", 0, 0, 0);
        for (int i = 0; i < WAKE_N; i++) cyc("t5_wk", 0, 0, 1);
        chk("t5_ready", 32'(ready), 32'd1);
        for (int i = 0; i < IDLE_N + 3; i++) cyc("t5_regate", 0, 0, 1);
        do_reset("t5");

        // 6: statistics count and saturate
        for (int i = 0; i < IDLE_N + 10; i++) cyc("t6_g10", 0, 0, 1);
`ifdef CLKGATE_STATS_EN
        chk("t6_stat10", 32'(gated_cycles), 32'd10);
`endif
        for (int i = 0; i < 20; i++) cyc("t6_g20", 0, 0, 1);
`ifdef CLKGATE_STATS_EN
        chk("t6_stat_sat", 32'(gated_cycles), 32'd15);
`endif
        do_reset("t6");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rnd",
                logic'($urandom_range(0, 9) == 0),
                logic'($urandom_range(0, 11) == 0),
                logic'($urandom_range(0, 19) != 0));
            if ($urandom_range(0, 149) == 0) do_reset("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
